// File: rtl/lp_pipe_result_sink.sv
`default_nettype none
// ============================================================================
// Module   : lp_pipe_result_sink
// Brief    : Result sink for the low-power piped-operator output handshake.
//            Buffers pushed results in a FWFT FIFO with registered
//            backpressure, and flags protocol and ID-sequence errors.
// Revision : 1.0 - initial release
// ============================================================================
module lp_pipe_result_sink #(
    parameter int data_width   = 32,
    parameter int status_width = 8,
    parameter int id_width     = 8,
    parameter int depth        = 4,
    parameter int id_check     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arrive,
    input  logic [id_width-1:0]          arrive_id,
    input  logic [data_width-1:0]        z,
    input  logic [status_width-1:0]      status,
    input  logic                         push_out_n,
    output logic                         accept_n,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [data_width-1:0]        out_z,
    output logic [status_width-1:0]      out_status,
    output logic [id_width-1:0]          out_id,
    output logic [$clog2(depth+1)-1:0]   census,
    output logic                         full,
    output logic                         proto_err,
    output logic                         id_err
);

    localparam int c_ptr_w = $clog2(depth);
    localparam int c_cnt_w = $clog2(depth + 1);
    localparam int c_ent_w = data_width + status_width + id_width;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(depth);

    logic [c_ent_w-1:0]  r_mem [depth];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_census;
    logic                r_accept_n;
    logic                r_proto_err;
    logic                r_id_err;
    logic [id_width-1:0] r_exp_id;

    logic                w_push;
    logic                w_pop;
    logic                w_proto_viol;
    logic                w_id_miss;
    logic [c_cnt_w-1:0]  w_census_next;

    assign w_push       = ~push_out_n & ~r_accept_n;
    assign w_pop        = (r_census != '0) & out_ready;
    assign w_proto_viol = ~push_out_n & (r_accept_n | ~arrive);
    assign w_id_miss    = (id_check != 0) && w_push && (arrive_id != r_exp_id);

    always_comb begin
        w_census_next = r_census;
        if (w_push && !w_pop) begin
            w_census_next = r_census + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
            w_census_next = r_census - c_cnt_w'(1);
        end
    end

    // Storage is cleared on reset so the head ports read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {z, status, arrive_id};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_census   <= '0;
            r_accept_n <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_census   <= w_census_next;
            // Backpressure looks at the post-update occupancy so a full FIFO
            // never sees a push and no skid storage is needed.
            r_accept_n <= (w_census_next == c_depth);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proto_err <= 1'b0;
            r_id_err    <= 1'b0;
            r_exp_id    <= '0;
        end else begin
            if (w_proto_viol) begin
                r_proto_err <= 1'b1;
            end
            if (w_id_miss) begin
                r_id_err <= 1'b1;
            end
            // Resynchronise to the observed ID whether or not it matched.
            if (w_push) begin
                r_exp_id <= arrive_id + id_width'(1);
            end
        end
    end

    assign {out_z, out_status, out_id} = r_mem[r_rd_ptr];
    assign out_valid = (r_census != '0);
    assign census    = r_census;
    assign full      = (r_census == c_depth);
    assign accept_n  = r_accept_n;
    assign proto_err = r_proto_err;
    assign id_err    = r_id_err;

endmodule
`default_nettype wire

// File: tb/tb_lp_pipe_result_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_lp_pipe_result_sink
// Brief    : Scoreboard bench for lp_pipe_result_sink with a queue-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lp_pipe_result_sink;

    localparam int DW    = 32;
    localparam int SW    = 8;
    localparam int IW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int EW    = DW + SW + IW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arrive = 1'b0;
    logic [IW-1:0] arrive_id = '0;
    logic [DW-1:0] z = '0;
    logic [SW-1:0] status = '0;
    logic          push_out_n = 1'b1;
    logic          accept_n;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_z;
    logic [SW-1:0] out_status;
    logic [IW-1:0] out_id;
    logic [CW-1:0] census;
    logic          full;
    logic          proto_err;
    logic          id_err;

    always #5 clk = ~clk;

    lp_pipe_result_sink #(
        .data_width   (DW),
        .status_width (SW),
        .id_width     (IW),
        .depth        (DEPTH),
        .id_check     (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arrive     (arrive),
        .arrive_id  (arrive_id),
        .z          (z),
        .status     (status),
        .push_out_n (push_out_n),
        .accept_n   (accept_n),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_status (out_status),
        .out_id     (out_id),
        .census     (census),
        .full       (full),
        .proto_err  (proto_err),
        .id_err     (id_err)
    );

    int            checks = 0;
    int            errors = 0;
    logic [EW-1:0] q[$];
    bit            issued = 1'b0;
    bit            mon_en = 1'b0;
    bit            m_proto = 1'b0;
    bit            m_id = 1'b0;
    logic [IW-1:0] m_exp = '0;
    logic [IW-1:0] rid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle; the expected entry is queued when the model says
    // the sink has room (occupancy below depth).
    task automatic cyc(input bit arr, input bit psh, input logic [IW-1:0] id,
                       input logic [DW-1:0] zz, input logic [SW-1:0] st, input bit rdy);
        @(posedge clk);
        #1;
        arrive     = arr;
        push_out_n = ~psh;
        arrive_id  = id;
        z          = zz;
        status     = st;
        out_ready  = rdy;
        if (psh && q.size() != DEPTH) begin
            q.push_back({zz, st, id});
            issued = 1'b1;
        end else begin
            issued = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        mon_en     = 1'b0;
        rst_n      = 1'b0;
        push_out_n = 1'b1;
        arrive     = 1'b0;
        out_ready  = 1'b0;
        issued     = 1'b0;
        #1;
        chk("rst_accept_n", accept_n, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_census", census, 0);
        chk("rst_full", full, 0);
        chk("rst_out_z", out_z, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_id_err", id_err, 0);
        q.delete();
        m_proto = 1'b0;
        m_id    = 1'b0;
        m_exp   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_accept_n_pre_edge", accept_n, 1);
        @(posedge clk);
        #1;
        chk("release_accept_n_post_edge", accept_n, 0);
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        int            mc;
        logic [EW-1:0] head;
        if (mon_en) begin
            mc = q.size() - (issued ? 1 : 0);
            chk("census", census, mc);
            chk("out_valid", out_valid, (mc != 0));
            chk("full", full, (mc == DEPTH));
            chk("accept_n", accept_n, (mc == DEPTH));
            chk("proto_err", proto_err, m_proto);
            chk("id_err", id_err, m_id);
            if (mc != 0 && out_ready) begin
                head = q[0];
                chk("out_z", out_z, head[EW-1:SW+IW]);
                chk("out_status", out_status, head[SW+IW-1:IW]);
                chk("out_id", out_id, head[IW-1:0]);
                void'(q.pop_front());
            end
            if (!push_out_n && (mc == DEPTH || !arrive)) m_proto = 1'b1;
            if (issued) begin
                if (arrive_id != m_exp) m_id = 1'b1;
                m_exp = arrive_id + 8'd1;
            end
        end
    end

    initial begin
        logic [IW-1:0] ids [9];
        ids = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd9, 8'd10};

        do_reset();

        // Fill to depth with the consumer stalled.
        for (int i = 0; i < DEPTH; i++) cyc(1, 1, 8'(i), $urandom, 8'($urandom), 0);
        cyc(0, 0, '0, '0, '0, 0);
        cyc(0, 0, '0, '0, '0, 0);

        // Push into a full sink: dropped, flagged.
        cyc(1, 1, 8'd4, 32'hDEADBEEF, 8'h5A, 0);
        cyc(0, 0, '0, '0, '0, 0);

        // Drain in order.
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, '0, '0, '0, 1);
        chk("drained_out_valid", out_valid, 0);

        // Streaming push+pop every cycle, passing through 0xF0 and wrapping.
        do_reset();
        for (int i = 0; i < 540; i++) cyc(1, 1, 8'(i), $urandom, 8'($urandom), 1);
        cyc(0, 0, '0, '0, '0, 1);
        cyc(0, 0, '0, '0, '0, 1);
        chk("stream_id_err", id_err, 0);
        chk("stream_proto_err", proto_err, 0);

        // ID gap: 5,6 in sequence, then 9 out of sequence, then 10 resynced.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1, 1, ids[i], $urandom, 8'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, '0, '0, '0, 1);
        chk("gap_id_err", id_err, 1);

        // Randomised traffic with occasional ID skips and protocol faults.
        do_reset();
        rid = '0;
        for (int i = 0; i < 400; i++) begin
            bit          psh;
            bit          arr;
            psh = ($urandom_range(0, 3) != 0);
            arr = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 15) == 0) rid = rid + 8'd2;
            cyc(arr, psh, rid, $urandom, 8'($urandom), 1'($urandom_range(0, 2) != 0));
            if (issued) rid = rid + 8'd1;
        end
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, '0, '0, '0, 1);
        chk("final_census", census, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
